hazard3_operand_fetch: RTL



---
 rtl/hazard3_opfetch_pkg.sv | 9 +
 rtl/hazard3_opfetch_fwd.sv | 68 ++++++
 rtl/hazard3_operand_fetch.sv | 108 ++++++++++
 3 files changed

// File: rtl/hazard3_opfetch_pkg.sv
// rtl/hazard3_opfetch_pkg.sv - shared constants for the hazard3 operand-fetch stage
package hazard3_opfetch_pkg;

  localparam int unsigned X0         = 0;
  localparam int unsigned W_ADDR_DEF = 5;
  localparam int unsigned W_DATA_DEF = 32;
  localparam int unsigned N_REGS_DEF = 1 << W_ADDR_DEF;

endpackage

// File: rtl/hazard3_opfetch_fwd.sv
// rtl/hazard3_opfetch_fwd.sv - per-port writeback collision detect and operand mux
// Forwarding datapath present only when HAZARD3_OPFETCH_BYPASS_EN is defined.
module hazard3_opfetch_fwd
  import hazard3_opfetch_pkg::*;
#(
  parameter int W_ADDR = W_ADDR_DEF,
  parameter int W_DATA = W_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_ADDR-1:0] raddr,
  input  logic [W_ADDR-1:0] s1_rs,
  input  logic [W_DATA-1:0] rf_rdata,
  input  logic              wb_wen,
  input  logic [W_ADDR-1:0] wb_waddr,
  input  logic [W_DATA-1:0] wb_wdata,
  output logic              fwd_hit,
  output logic [W_DATA-1:0] op_data
);

  localparam logic [W_ADDR-1:0] X0_IDX = W_ADDR'(X0);

  logic hit_next;

  // The register file returns the pre-write value when a write and read of the
  // same index share an edge; remember that collision for the next cycle.
  assign hit_next = wb_wen && (wb_waddr == raddr) && (raddr != X0_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hit <= 1'b0;
    end else begin
      fwd_hit <= hit_next;
    end
  end

`ifdef HAZARD3_OPFETCH_BYPASS_EN
  logic [W_DATA-1:0] fwd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_data <= '0;
    end else begin
      fwd_data <= wb_wdata;
    end
  end

  always_comb begin
    op_data = rf_rdata;
    if (s1_rs == X0_IDX) begin
      op_data = '0;
    end else if (fwd_hit) begin
      op_data = fwd_data;
    end
  end
`else
  logic unused_wdata;
  assign unused_wdata = ^wb_wdata;

  always_comb begin
    op_data = rf_rdata;
    if (s1_rs == X0_IDX) begin
      op_data = '0;
    end
  end
`endif

endmodule

// File: rtl/hazard3_operand_fetch.sv
// rtl/hazard3_operand_fetch.sv - operand fetch between decode and execute
// Collision handling: forward with HAZARD3_OPFETCH_BYPASS_EN, else replay the read.
module hazard3_operand_fetch
  import hazard3_opfetch_pkg::*;
#(
  parameter int N_REGS = N_REGS_DEF,
  parameter int W_DATA = W_DATA_DEF,
  parameter int W_ADDR = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [W_ADDR-1:0] dec_rs1,
  input  logic [W_ADDR-1:0] dec_rs2,
  output logic [W_ADDR-1:0] rf_raddr1,
  output logic [W_ADDR-1:0] rf_raddr2,
  input  logic [W_DATA-1:0] rf_rdata1,
  input  logic [W_DATA-1:0] rf_rdata2,
  input  logic              wb_wen,
  input  logic [W_ADDR-1:0] wb_waddr,
  input  logic [W_DATA-1:0] wb_wdata,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [W_ADDR-1:0] op_rs1,
  output logic [W_ADDR-1:0] op_rs2,
  output logic [W_DATA-1:0] op_rs1_data,
  output logic [W_DATA-1:0] op_rs2_data
);

  logic              s1_valid;
  logic [W_ADDR-1:0] s1_rs1;
  logic [W_ADDR-1:0] s1_rs2;
  logic              handoff;
  logic              hold;
  logic              accept;
  logic              fwd_hit1;
  logic              fwd_hit2;

  assign handoff = op_valid && op_ready;
  assign hold    = s1_valid && !handoff;

  // Reissue the held addresses every stalled cycle so late writebacks are seen.
  assign rf_raddr1 = hold ? s1_rs1 : dec_rs1;
  assign rf_raddr2 = hold ? s1_rs2 : dec_rs2;

  assign dec_ready = !rst && (!s1_valid || handoff);
  assign accept    = dec_valid && dec_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_rs1   <= dec_rs1;
      s1_rs2   <= dec_rs2;
    end else if (handoff) begin
      s1_valid <= 1'b0;
    end
  end

`ifdef HAZARD3_OPFETCH_BYPASS_EN
  logic unused_fwd_hit;
  assign unused_fwd_hit = fwd_hit1 ^ fwd_hit2;
  assign op_valid       = s1_valid;
`else
  // A collision leaves stale data in the read register; stall one cycle for the replay.
  assign op_valid = s1_valid && !fwd_hit1 && !fwd_hit2;
`endif

  assign op_rs1 = s1_rs1;
  assign op_rs2 = s1_rs2;

  hazard3_opfetch_fwd #(
    .W_ADDR (W_ADDR),
    .W_DATA (W_DATA)
  ) u_fwd1 (
    .clk      (clk),
    .rst      (rst),
    .raddr    (rf_raddr1),
    .s1_rs    (s1_rs1),
    .rf_rdata (rf_rdata1),
    .wb_wen   (wb_wen),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .fwd_hit  (fwd_hit1),
    .op_data  (op_rs1_data)
  );

  hazard3_opfetch_fwd #(
    .W_ADDR (W_ADDR),
    .W_DATA (W_DATA)
  ) u_fwd2 (
    .clk      (clk),
    .rst      (rst),
    .raddr    (rf_raddr2),
    .s1_rs    (s1_rs2),
    .rf_rdata (rf_rdata2),
    .wb_wen   (wb_wen),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .fwd_hit  (fwd_hit2),
    .op_data  (op_rs2_data)
  );

endmodule
